// File: rtl/bnn_sched_pkg.sv
// rtl/bnn_sched_pkg.sv - shared state encoding and constants for the BNN job scheduler
package bnn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    CLEAR
  } sched_state_t;

  localparam logic [3:0] RESULT_TIMEOUT  = 4'hF;
  localparam int         DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin requester selection with an internal priority pointer
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     accept,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] step(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Walk from the farthest slot to the nearest so the index right after ptr wins.
  always_comb begin
    grant_idx = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[step(ptr, k)]) grant_idx = step(ptr, k);
    end
    grant = '0;
    if (|req) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= IW'(N_REQ - 1);
    else if (accept) ptr <= grant_idx;
  end

endmodule

// File: rtl/bnn_job_scheduler.sv
// rtl/bnn_job_scheduler.sv - shares one BNN engine between N_REQ image producers
module bnn_job_scheduler import bnn_sched_pkg::*; #(
  parameter int N_REQ          = 2,
  parameter int IMG_BITS       = 904,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n_pin,
  input  logic [N_REQ-1:0]    req,
  input  logic [IMG_BITS-1:0] req_img [N_REQ],
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic [3:0]          result_out,
  output logic                result_valid,
  output logic                timeout_err,
  output logic                busy,
  output logic [15:0]         job_count,
  output logic [IMG_BITS-1:0] bnn_img,
  output logic                bnn_img_full,
  output logic                bnn_enable,
  output logic                bnn_clear,
  input  logic                bnn_result_ready,
  input  logic [3:0]          bnn_result
);

  localparam int            IW      = $clog2(N_REQ);
  localparam int            WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [1:0]     rst_sync;
  logic           rst_n;
  sched_state_t   state;
  logic [WDW-1:0] wd;
  logic           err;
  logic           accept;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]  arb_idx;

  // Assert immediately, release two edges after the pin goes high.
  always_ff @(posedge clk or negedge rst_n_pin) begin
    if (!rst_n_pin) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign accept = (state == IDLE) && (|req);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .accept    (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wd           <= '0;
      err          <= 1'b0;
      grant        <= '0;
      done         <= '0;
      result_out   <= 4'h0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      job_count    <= 16'h0000;
      bnn_img      <= '0;
      bnn_img_full <= 1'b0;
      bnn_enable   <= 1'b0;
      bnn_clear    <= 1'b0;
    end else begin
      done         <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      bnn_clear    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant   <= arb_grant;
            bnn_img <= req_img[arb_idx];
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          bnn_img_full <= 1'b1;
          bnn_enable   <= 1'b1;
          wd           <= '0;
          state        <= RUN;
        end
        RUN: begin
          // A strobe on the final watchdog cycle still counts as success.
          if (bnn_result_ready) begin
            result_out <= bnn_result;
            err        <= 1'b0;
            state      <= DONE;
          end else if (wd == WD_LAST) begin
            result_out <= RESULT_TIMEOUT;
            err        <= 1'b1;
            state      <= DONE;
          end else begin
            wd <= wd + WDW'(1);
          end
        end
        DONE: begin
          done         <= grant;
          result_valid <= !err;
          timeout_err  <= err;
          job_count    <= job_count + 16'd1;
          state        <= CLEAR;
        end
        CLEAR: begin
          bnn_clear    <= 1'b1;
          bnn_enable   <= 1'b0;
          bnn_img_full <= 1'b0;
          grant        <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_job_scheduler.sv
// tb/tb_bnn_job_scheduler.sv - self-checking bench for bnn_job_scheduler
module tb_bnn_job_scheduler;

  localparam int NR = 2;
  localparam int IB = 64;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst_n_pin;
  logic [NR-1:0] req;
  logic [IB-1:0] req_img [NR];
  logic [NR-1:0] grant, done;
  logic [3:0]    result_out;
  logic          result_valid, timeout_err, busy;
  logic [15:0]   job_count;
  logic [IB-1:0] bnn_img;
  logic          bnn_img_full, bnn_enable, bnn_clear;
  logic          bnn_result_ready;
  logic [3:0]    bnn_result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int jc     = 0;
  int ptr_m  = NR - 1;

  bnn_job_scheduler #(.N_REQ(NR), .IMG_BITS(IB), .TIMEOUT_CYCLES(T)) dut (
    .clk              (clk),
    .rst_n_pin        (rst_n_pin),
    .req              (req),
    .req_img          (req_img),
    .grant            (grant),
    .done             (done),
    .result_out       (result_out),
    .result_valid     (result_valid),
    .timeout_err      (timeout_err),
    .busy             (busy),
    .job_count        (job_count),
    .bnn_img          (bnn_img),
    .bnn_img_full     (bnn_img_full),
    .bnn_enable       (bnn_enable),
    .bnn_clear        (bnn_clear),
    .bnn_result_ready (bnn_result_ready),
    .bnn_result       (bnn_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference arbitration: first requester strictly after the last winner, circularly.
  function automatic int rr_pick(input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    end
    return 0;
  endfunction

  // One complete job: present request, play the BNN with a strobe after lat RUN cycles.
  task automatic run_job(input logic [NR-1:0] r, input int lat, input logic [3:0] res,
                         input logic drop, input logic [NR-1:0] eg, input logic eerr,
                         input logic [3:0] eres, input int ewait, output int acc_cyc);
    int w;
    int ne;
    logic [IB-1:0] gimg;
    req_img[0] = {$urandom, $urandom};
    req_img[1] = {$urandom, $urandom};
    req = r;
    w = 0;
    acc_cyc = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant == '0 && w < 40);
    if (grant == '0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=no_grant required=grant");
      return;
    end
    acc_cyc = cyc;
    if (ewait > 0) chk("accept_wait", 64'(w), 64'(ewait));
    chk("grant", 64'(grant), 64'(eg));
    gimg = eg[1] ? req_img[1] : req_img[0];
    chk("bnn_img", 64'(bnn_img), 64'(gimg));
    chk("busy_on", 64'(busy), 64'd1);
    ptr_m = eg[1] ? 1 : 0;
    ne = (lat <= T) ? lat : T;
    for (int c = 0; c <= ne + 3; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c <= ne + 1)
          chk("run_phase", 64'({busy, bnn_enable, bnn_img_full, done, grant}),
              64'({3'b111, 2'b00, eg}));
        if (c == ne + 2) begin
          chk("done", 64'(done), 64'(eg));
          chk("flags", 64'({result_valid, timeout_err, bnn_clear}), 64'({!eerr, eerr, 1'b0}));
          chk("result_out", 64'(result_out), 64'(eres));
          chk("job_count", 64'(job_count), 64'(16'(jc + 1)));
        end
        if (c == ne + 3) begin
          chk("clear_phase",
              64'({done, result_valid, timeout_err, bnn_clear, grant, busy, bnn_enable, bnn_img_full}),
              64'({2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0}));
          chk("result_hold", 64'(result_out), 64'(eres));
        end
      end
      bnn_result_ready = (c == lat);
      bnn_result = (c == lat) ? res : 4'($urandom);
      if (drop && c == 1) req = '0;
    end
    bnn_result_ready = 1'b0;
    jc++;
  endtask

  typedef struct {
    logic [NR-1:0] r;
    int            lat;
    logic [3:0]    res;
    logic          drop;
    logic [NR-1:0] eg;
    logic          eerr;
    logic [3:0]    eres;
    int            ewait;
  } vec_t;

  vec_t tbl[6];
  int   rr_exp[4];

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int acc, acc_prev, w, g, lat;
    logic [NR-1:0] r, eg;
    logic [3:0] res;
    logic eerr;

    tbl[0] = '{2'b01, 10, 4'h7, 1'b0, 2'b01, 1'b0, 4'h7, 3};
    tbl[1] = '{2'b10, 16, 4'h3, 1'b1, 2'b10, 1'b0, 4'h3, 1};
    tbl[2] = '{2'b01, 17, 4'h5, 1'b0, 2'b01, 1'b1, 4'hF, 1};
    tbl[3] = '{2'b11,  1, 4'h9, 1'b1, 2'b10, 1'b0, 4'h9, 1};
    tbl[4] = '{2'b11,  2, 4'h0, 1'b0, 2'b01, 1'b0, 4'h0, 1};
    tbl[5] = '{2'b10, 18, 4'hC, 1'b1, 2'b10, 1'b1, 4'hF, 1};
    rr_exp = '{0, 1, 0, 1};

    rst_n_pin = 1'b0;
    req = '0;
    req_img[0] = '0;
    req_img[1] = '0;
    bnn_result_ready = 1'b0;
    bnn_result = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({grant, done, result_valid, timeout_err, busy, bnn_img_full, bnn_enable, bnn_clear}), 64'd0);
    chk("reset_data", 64'({result_out, job_count}), 64'd0);
    chk("reset_img", 64'(bnn_img), 64'd0);

    // Release with a request pending; the first row expects the grant on the third edge.
    rst_n_pin = 1'b1;
    for (int i = 0; i < 6; i++)
      run_job(tbl[i].r, tbl[i].lat, tbl[i].res, tbl[i].drop, tbl[i].eg, tbl[i].eerr,
              tbl[i].eres, tbl[i].ewait, acc);

    // Stray strobe while idle.
    bnn_result_ready = 1'b1;
    bnn_result = 4'h2;
    @(negedge clk);
    bnn_result_ready = 1'b0;
    @(negedge clk);
    chk("stray_ctl", 64'({grant, done, busy, result_valid, timeout_err}), 64'd0);
    chk("stray_result", 64'(result_out), 64'hF);
    chk("stray_count", 64'(job_count), 64'(16'(jc)));

    // Held request from both producers alternates and re-accepts every N+4 cycles.
    acc_prev = 0;
    for (int j = 0; j < 4; j++) begin
      eg = 2'(1 << rr_exp[j]);
      run_job(2'b11, 3, 4'(j + 1), 1'b0, eg, 1'b0, 4'(j + 1), 1, acc);
      if (j > 0) chk("rr_spacing", 64'(acc - acc_prev), 64'd7);
      acc_prev = acc;
    end
    chk("rr_count", 64'(job_count), 64'd10);

    // Reset in the middle of RUN.
    req = 2'b01;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant == '0 && w < 40);
    chk("midrst_grant", 64'(grant), 64'(2'b01));
    repeat (4) @(negedge clk);
    rst_n_pin = 1'b0;
    #1;
    chk("midrst_ctl", 64'({grant, done, busy, bnn_img_full, bnn_enable, bnn_clear, result_valid, timeout_err}), 64'd0);
    chk("midrst_data", 64'({result_out, job_count}), 64'd0);
    chk("midrst_img", 64'(bnn_img), 64'd0);
    req = '0;
    repeat (2) @(negedge clk);
    chk("midrst_hold", 64'({done, bnn_clear, busy}), 64'd0);
    rst_n_pin = 1'b1;
    jc = 0;
    ptr_m = NR - 1;
    run_job(2'b10, 5, 4'h6, 1'b0, 2'b10, 1'b0, 4'h6, 3, acc);

    // Randomised jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      r    = 2'($urandom_range(1, 3));
      lat  = $urandom_range(1, T + 2);
      res  = 4'($urandom);
      g    = rr_pick(r);
      eg   = 2'(1 << g);
      eerr = (lat > T);
      run_job(r, lat, res, 1'($urandom_range(0, 1)), eg, eerr, eerr ? 4'hF : res, 1, acc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
